// File: rtl/dmem_arbiter_ctrl_if.sv
// Bus bundle between the LSU / external loader, the arbiter and the byte-banked data RAM.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface dmem_arbiter_ctrl_if #(
  parameter int unsigned AW = 12
) ();
  logic          c_req_i;
  logic          c_we_i;
  logic [AW-1:0] c_addr_i;
  logic [2:0]    c_funct3_i;
  logic [31:0]   c_wdata_i;
  logic          c_gnt_o;
  logic          c_rvalid_o;
  logic [31:0]   c_rdata_o;
  logic          c_err_o;

  logic          e_req_i;
  logic          e_we_i;
  logic [AW-1:0] e_addr_i;
  logic [3:0]    e_be_i;
  logic [31:0]   e_wdata_i;
  logic          e_gnt_o;
  logic          e_rvalid_o;
  logic [31:0]   e_rdata_o;

  logic [AW-1:0] mem_addr_o;
  logic          mem_write_o;
  logic          mem_read_o;
  logic [3:0]    mem_size_o;
  logic [31:0]   mem_din_o;
  logic [31:0]   mem_dout_i;

  modport slave (
    input  c_req_i, c_we_i, c_addr_i, c_funct3_i, c_wdata_i,
    output c_gnt_o, c_rvalid_o, c_rdata_o, c_err_o,
    input  e_req_i, e_we_i, e_addr_i, e_be_i, e_wdata_i,
    output e_gnt_o, e_rvalid_o, e_rdata_o,
    output mem_addr_o, mem_write_o, mem_read_o, mem_size_o, mem_din_o,
    input  mem_dout_i
  );

  modport master (
    output c_req_i, c_we_i, c_addr_i, c_funct3_i, c_wdata_i,
    input  c_gnt_o, c_rvalid_o, c_rdata_o, c_err_o,
    output e_req_i, e_we_i, e_addr_i, e_be_i, e_wdata_i,
    input  e_gnt_o, e_rvalid_o, e_rdata_o,
    input  mem_addr_o, mem_write_o, mem_read_o, mem_size_o, mem_din_o,
    output mem_dout_i
  );
endinterface

// File: rtl/dmem_arbiter_ctrl.sv
// Two-port data-memory arbiter: core LSU (RISC-V sub-word loads/stores) and an external word
// port share one byte-banked RAM with 1-cycle registered read latency.
module dmem_arbiter_ctrl #(
  parameter int unsigned DMEM_ADDR_WIDTH = 12,
  parameter bit          ROUND_ROBIN     = 1'b1
) (
  input logic                clk_i,
  input logic                rst_i,
  dmem_arbiter_ctrl_if.slave bus
);

  typedef enum logic {LastCore, LastExt} last_e;

  last_e      last_q, last_d;
  logic       c_gnt, e_gnt;
  logic [1:0] c_off;
  logic       c_illegal, c_misal, c_err;

  logic       c_pend_q, c_err_q, c_load_q, e_pend_q;
  logic [1:0] c_off_q;
  logic [2:0] c_f3_q;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] c_rdata;

  logic unused_e_addr;
  assign unused_e_addr = ^bus.e_addr_i[1:0];

  assign c_off = bus.c_addr_i[1:0];

  always_comb begin
    if (bus.c_we_i) begin
      c_illegal = bus.c_funct3_i[2] | (bus.c_funct3_i[1:0] == 2'b11);
    end else begin
      c_illegal = (bus.c_funct3_i[1:0] == 2'b11) | (bus.c_funct3_i == 3'b110);
    end
    c_misal = ((bus.c_funct3_i[1:0] == 2'b01) & c_off[0]) |
              ((bus.c_funct3_i[1:0] == 2'b10) & (c_off != 2'b00));
    c_err   = c_illegal | c_misal;
  end

  // The pointer names the last winner; under contention the other side wins.
  always_comb begin
    c_gnt  = bus.c_req_i & (~bus.e_req_i | ~ROUND_ROBIN | (last_q == LastExt));
    e_gnt  = bus.e_req_i & ~c_gnt;
    last_d = last_q;
    if (c_gnt) begin
      last_d = LastCore;
    end else if (e_gnt) begin
      last_d = LastExt;
    end
  end

  assign bus.c_gnt_o = c_gnt;
  assign bus.e_gnt_o = e_gnt;

  always_comb begin
    bus.mem_addr_o  = '0;
    bus.mem_read_o  = 1'b0;
    bus.mem_write_o = 1'b0;
    bus.mem_size_o  = 4'b0000;
    bus.mem_din_o   = '0;
    if (c_gnt) begin
      bus.mem_addr_o = bus.c_addr_i;
      if (!c_err) begin
        bus.mem_read_o  = ~bus.c_we_i;
        bus.mem_write_o = bus.c_we_i;
        bus.mem_size_o  = 4'b1111;
        bus.mem_din_o   = bus.c_wdata_i;
        if (bus.c_we_i) begin
          case (bus.c_funct3_i[1:0])
            2'b00: begin
              bus.mem_size_o = 4'b0001 << c_off;
              bus.mem_din_o  = {4{bus.c_wdata_i[7:0]}};
            end
            2'b01: begin
              bus.mem_size_o = 4'b0011 << c_off;
              bus.mem_din_o  = {2{bus.c_wdata_i[15:0]}};
            end
            default: ;
          endcase
        end
      end
    end else if (e_gnt) begin
      bus.mem_addr_o  = {bus.e_addr_i[DMEM_ADDR_WIDTH-1:2], 2'b00};
      bus.mem_size_o  = bus.e_be_i;
      bus.mem_din_o   = bus.e_wdata_i;
      bus.mem_read_o  = ~bus.e_we_i;
      bus.mem_write_o = bus.e_we_i & (|bus.e_be_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q   <= LastExt;
      c_pend_q <= 1'b0;
      c_err_q  <= 1'b0;
      c_load_q <= 1'b0;
      c_off_q  <= 2'b00;
      c_f3_q   <= 3'b000;
      e_pend_q <= 1'b0;
    end else begin
      last_q   <= last_d;
      c_pend_q <= c_gnt;
      c_err_q  <= c_gnt & c_err;
      c_load_q <= c_gnt & ~bus.c_we_i & ~c_err;
      e_pend_q <= e_gnt;
      if (c_gnt) begin
        c_off_q <= c_off;
        c_f3_q  <= bus.c_funct3_i;
      end
    end
  end

  // Sub-word extraction works on the RAM word in the response cycle.
  always_comb begin
    case (c_off_q)
      2'd0:    byte_sel = bus.mem_dout_i[7:0];
      2'd1:    byte_sel = bus.mem_dout_i[15:8];
      2'd2:    byte_sel = bus.mem_dout_i[23:16];
      default: byte_sel = bus.mem_dout_i[31:24];
    endcase
    half_sel = c_off_q[1] ? bus.mem_dout_i[31:16] : bus.mem_dout_i[15:0];
    c_rdata  = '0;
    if (c_load_q) begin
      case (c_f3_q)
        3'b000:  c_rdata = {{24{byte_sel[7]}}, byte_sel};
        3'b100:  c_rdata = {24'h0, byte_sel};
        3'b001:  c_rdata = {{16{half_sel[15]}}, half_sel};
        3'b101:  c_rdata = {16'h0, half_sel};
        default: c_rdata = bus.mem_dout_i;
      endcase
    end
  end

  assign bus.c_rvalid_o = c_pend_q;
  assign bus.c_err_o    = c_pend_q & c_err_q;
  assign bus.c_rdata_o  = c_rdata;
  assign bus.e_rvalid_o = e_pend_q;
  assign bus.e_rdata_o  = e_pend_q ? bus.mem_dout_i : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// Bench for dmem_arbiter_ctrl: directed sub-word cases, errors, arbitration, reset abort and a
// randomized run checked against a byte-array memory model.
module tb_dmem_arbiter_ctrl;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_ctrl_if #(.AW(AW)) bus0 ();
  dmem_arbiter_ctrl_if #(.AW(AW)) bus1 ();

  dmem_arbiter_ctrl #(.DMEM_ADDR_WIDTH(AW), .ROUND_ROBIN(1'b1)) u_rr (
    .clk_i(clk), .rst_i(rst), .bus(bus0)
  );
  dmem_arbiter_ctrl #(.DMEM_ADDR_WIDTH(AW), .ROUND_ROBIN(1'b0)) u_pri (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );

  // RAM attached to the round-robin instance.
  logic [7:0]  ram [4096] = '{default: 8'h00};
  logic [31:0] ram_dout = '0;
  assign bus0.mem_dout_i = ram_dout;
  assign bus1.mem_dout_i = 32'h0;

  always @(posedge clk) begin
    if (bus0.mem_write_o) begin
      for (int i = 0; i < 4; i++) begin
        if (bus0.mem_size_o[i]) ram[{bus0.mem_addr_o[AW-1:2], 2'(i)}] <= bus0.mem_din_o[8*i +: 8];
      end
    end
    if (bus0.mem_read_o) begin
      ram_dout <= {ram[{bus0.mem_addr_o[AW-1:2], 2'd3}], ram[{bus0.mem_addr_o[AW-1:2], 2'd2}],
                   ram[{bus0.mem_addr_o[AW-1:2], 2'd1}], ram[{bus0.mem_addr_o[AW-1:2], 2'd0}]};
    end
  end

  // Reference memory, updated from the architectural meaning of each access.
  logic [7:0] ref_mem [4096];

  int total = 0;
  int bad   = 0;

  logic          s_cg, s_eg, s_rd, s_wr;
  logic [3:0]    s_sz;
  logic [31:0]   s_din;
  logic          r_cv, r_ce, r_ev;
  logic [31:0]   r_cd, r_ed;

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a - (a % 4);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] ref_load(input int a, input logic [2:0] f3);
    logic [7:0]  bv;
    logic [15:0] hv;
    bv = ref_mem[a];
    hv = {ref_mem[(a+1)%4096], ref_mem[a]};
    case (f3)
      3'b000:  return {{24{bv[7]}}, bv};
      3'b100:  return {24'h0, bv};
      3'b001:  return {{16{hv[15]}}, hv};
      3'b101:  return {16'h0, hv};
      default: return ref_word(a);
    endcase
  endfunction

  function automatic bit ref_err(input bit we, input int a, input logic [2:0] f3);
    bit legal;
    int sz;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    sz = 1 << f3[1:0];
    return !legal || ((a % sz) != 0);
  endfunction

  task automatic ref_store(input int a, input logic [2:0] f3, input logic [31:0] d);
    for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[a+i] = d[8*i +: 8];
  endtask

  task automatic ref_ext_write(input int a, input logic [3:0] be, input logic [31:0] d);
    int b;
    b = a - (a % 4);
    for (int i = 0; i < 4; i++) if (be[i]) ref_mem[b+i] = d[8*i +: 8];
  endtask

  // One cycle on bus0: drive, sample the combinational side, then the response after the edge.
  task automatic step(input logic cr, input logic cw, input logic [AW-1:0] ca,
                      input logic [2:0] f3, input logic [31:0] cd, input logic er,
                      input logic ew, input logic [AW-1:0] ea, input logic [3:0] be,
                      input logic [31:0] ed);
    bus0.c_req_i = cr; bus0.c_we_i = cw; bus0.c_addr_i = ca;
    bus0.c_funct3_i = f3; bus0.c_wdata_i = cd;
    bus0.e_req_i = er; bus0.e_we_i = ew; bus0.e_addr_i = ea;
    bus0.e_be_i = be; bus0.e_wdata_i = ed;
    #3;
    s_cg = bus0.c_gnt_o; s_eg = bus0.e_gnt_o;
    s_rd = bus0.mem_read_o; s_wr = bus0.mem_write_o;
    s_sz = bus0.mem_size_o; s_din = bus0.mem_din_o;
    @(posedge clk);
    #1;
    r_cv = bus0.c_rvalid_o; r_ce = bus0.c_err_o; r_cd = bus0.c_rdata_o;
    r_ev = bus0.e_rvalid_o; r_ed = bus0.e_rdata_o;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 3'b0, '0, 1'b0, 1'b0, '0, 4'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({bus0.c_gnt_o, bus0.e_gnt_o, bus0.c_rvalid_o, bus0.e_rvalid_o, bus0.c_err_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 00000",
               {bus0.c_gnt_o, bus0.e_gnt_o, bus0.c_rvalid_o, bus0.e_rvalid_o, bus0.c_err_o});
    end
    total++;
    if ({bus0.c_rdata_o, bus0.e_rdata_o} !== 64'h0) begin
      bad++;
      $display("FAIL reset_rdata: got %h %h want 0", bus0.c_rdata_o, bus0.e_rdata_o);
    end
    total++;
    if ({bus0.mem_read_o, bus0.mem_write_o, bus0.mem_size_o} !== 6'b0) begin
      bad++;
      $display("FAIL reset_mem: got %b want 000000",
               {bus0.mem_read_o, bus0.mem_write_o, bus0.mem_size_o});
    end
    rst = 1'b0;
  endtask

  task automatic test_subword();
    logic [AW-1:0] la [4] = '{12'h013, 12'h013, 12'h012, 12'h010};
    logic [2:0]    lf [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0]   le [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
    step(1'b1, 1'b1, 12'h010, 3'b010, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, 4'b0, '0);
    ref_store(12'h010, 3'b010, 32'hDEAD_BEEF);
    total++;
    if ({s_cg, s_wr, s_rd, s_sz} !== 7'b110_1111) begin
      bad++;
      $display("FAIL sw_strobe: got %b want 1101111", {s_cg, s_wr, s_rd, s_sz});
    end
    step(1'b1, 1'b0, 12'h010, 3'b010, '0, 1'b0, 1'b0, '0, 4'b0, '0);
    total++;
    if ({r_cv, r_ce, r_cd} !== {2'b10, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL lw_data: got v=%b e=%b %h want v=1 e=0 deadbeef", r_cv, r_ce, r_cd);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, la[i], lf[i], '0, 1'b0, 1'b0, '0, 4'b0, '0);
      total++;
      if (r_cd !== le[i] || r_cv !== 1'b1) begin
        bad++;
        $display("FAIL subload_%0d: got v=%b %h want v=1 %h", i, r_cv, r_cd, le[i]);
      end
    end
    step(1'b1, 1'b1, 12'h011, 3'b000, 32'h0000_0055, 1'b0, 1'b0, '0, 4'b0, '0);
    ref_store(12'h011, 3'b000, 32'h0000_0055);
    total++;
    if (s_sz !== 4'b0010 || s_din !== 32'h5555_5555) begin
      bad++;
      $display("FAIL sb_lanes: got size=%b din=%h want 0010 55555555", s_sz, s_din);
    end
    step(1'b1, 1'b0, 12'h010, 3'b010, '0, 1'b0, 1'b0, '0, 4'b0, '0);
    total++;
    if (r_cd !== 32'hDEAD_55EF) begin
      bad++;
      $display("FAIL lw_after_sb: got %h want dead55ef", r_cd);
    end
    idle();
  endtask

  task automatic test_errors();
    logic [AW-1:0] ea [2] = '{12'h006, 12'h020};
    logic [2:0]    ef [2] = '{3'b010, 3'b011};
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, ea[i], ef[i], '0, 1'b0, 1'b0, '0, 4'b0, '0);
      total++;
      if ({s_cg, s_rd, s_wr} !== 3'b100) begin
        bad++;
        $display("FAIL err_strobe_%0d: got gnt/rd/wr=%b want 100", i, {s_cg, s_rd, s_wr});
      end
      total++;
      if ({r_cv, r_ce, r_cd} !== {2'b11, 32'h0}) begin
        bad++;
        $display("FAIL err_resp_%0d: got v=%b e=%b %h want v=1 e=1 0", i, r_cv, r_ce, r_cd);
      end
    end
    idle();
  endtask

  task automatic test_contention();
    do_reset();
    bus0.c_req_i = 1'b1; bus0.c_we_i = 1'b0; bus0.c_addr_i = '0; bus0.c_funct3_i = 3'b010;
    bus0.e_req_i = 1'b1; bus0.e_we_i = 1'b0; bus0.e_addr_i = '0; bus0.e_be_i = 4'hF;
    bus1.c_req_i = 1'b1; bus1.c_we_i = 1'b0; bus1.c_addr_i = '0; bus1.c_funct3_i = 3'b010;
    bus1.e_req_i = 1'b1; bus1.e_we_i = 1'b0; bus1.e_addr_i = '0; bus1.e_be_i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #3;
      total++;
      if ({bus0.c_gnt_o, bus0.e_gnt_o} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL rr_grant_%0d: got c/e=%b%b want %s", k, bus0.c_gnt_o, bus0.e_gnt_o,
                 (k % 2 == 0) ? "C" : "E");
      end
      total++;
      if ({bus1.c_gnt_o, bus1.e_gnt_o} !== 2'b10) begin
        bad++;
        $display("FAIL pri_grant_%0d: got c/e=%b%b want 10", k, bus1.c_gnt_o, bus1.e_gnt_o);
      end
      @(posedge clk);
      #1;
      total++;
      if ({bus0.c_rvalid_o, bus0.e_rvalid_o} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL rr_rvalid_%0d: got c/e=%b%b", k, bus0.c_rvalid_o, bus0.e_rvalid_o);
      end
    end
    bus1.c_req_i = 1'b0; bus1.e_req_i = 1'b0;
    idle();
  endtask

  task automatic test_reset_abort();
    do_reset();
    bus0.c_req_i = 1'b0;
    bus0.e_req_i = 1'b1; bus0.e_we_i = 1'b0; bus0.e_addr_i = 12'h010; bus0.e_be_i = 4'hF;
    #3;
    total++;
    if (bus0.e_gnt_o !== 1'b1) begin
      bad++;
      $display("FAIL abort_grant: got %b want 1", bus0.e_gnt_o);
    end
    @(posedge clk);
    rst = 1'b1;
    bus0.e_req_i = 1'b0;
    #1;
    total++;
    if ({bus0.e_rvalid_o, bus0.c_rvalid_o, bus0.e_rdata_o, bus0.mem_read_o} !== 35'h0) begin
      bad++;
      $display("FAIL abort_outputs: got ev=%b cv=%b ed=%h rd=%b want all 0", bus0.e_rvalid_o,
               bus0.c_rvalid_o, bus0.e_rdata_o, bus0.mem_read_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    total++;
    if (r_ev !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_rvalid: got %b want 0", r_ev);
    end
    step(1'b1, 1'b0, 12'h010, 3'b010, '0, 1'b1, 1'b0, 12'h010, 4'hF, '0);
    total++;
    if ({s_cg, s_eg} !== 2'b10) begin
      bad++;
      $display("FAIL abort_core_first: got c/e=%b%b want 10", s_cg, s_eg);
    end
    idle();
  endtask

  task automatic test_random();
    bit last_ext;
    do_reset();
    last_ext = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic          cr, cw, er, ew, exp_cg, exp_eg, exp_ce;
      logic [AW-1:0] ca, ea;
      logic [2:0]    f3;
      logic [3:0]    be;
      logic [31:0]   cd, ed, exp_cd, exp_ed;
      cr = 1'($urandom); cw = 1'($urandom); er = 1'($urandom); ew = 1'($urandom);
      f3 = 3'($urandom_range(7));
      ca = AW'(12'h100 + $urandom_range(31));
      ea = AW'(12'h100 + $urandom_range(31));
      be = 4'($urandom); cd = $urandom; ed = $urandom;
      exp_cg = cr && (!er || last_ext);
      exp_eg = er && !exp_cg;
      exp_ce = exp_cg && ref_err(cw, int'(ca), f3);
      exp_cd = (exp_cg && !cw && !exp_ce) ? ref_load(int'(ca), f3) : 32'h0;
      exp_ed = ref_word(int'(ea));
      step(cr, cw, ca, f3, cd, er, ew, ea, be, ed);
      if (exp_cg && cw && !exp_ce) ref_store(int'(ca), f3, cd);
      if (exp_eg && ew) ref_ext_write(int'(ea), be, ed);
      if (exp_cg) last_ext = 1'b0;
      else if (exp_eg) last_ext = 1'b1;
      total++;
      if ({s_cg, s_eg} !== {exp_cg, exp_eg}) begin
        bad++;
        $display("FAIL rnd_grant_%0d: got c/e=%b%b want %b%b", n, s_cg, s_eg, exp_cg, exp_eg);
      end
      total++;
      if ({r_cv, r_ce, r_ev} !== {exp_cg, exp_ce, exp_eg}) begin
        bad++;
        $display("FAIL rnd_resp_%0d: got cv/ce/ev=%b%b%b want %b%b%b", n, r_cv, r_ce, r_ev,
                 exp_cg, exp_ce, exp_eg);
      end
      if (exp_cg && !cw) begin
        total++;
        if (r_cd !== exp_cd) begin
          bad++;
          $display("FAIL rnd_cdata_%0d: f3=%b addr=%h got %h want %h", n, f3, ca, r_cd, exp_cd);
        end
      end
      if (exp_eg && !ew) begin
        total++;
        if (r_ed !== exp_ed) begin
          bad++;
          $display("FAIL rnd_edata_%0d: addr=%h got %h want %h", n, ea, r_ed, exp_ed);
        end
      end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    rst = 1'b1;
    bus0.c_req_i = 1'b0; bus0.c_we_i = 1'b0; bus0.c_addr_i = '0; bus0.c_funct3_i = '0;
    bus0.c_wdata_i = '0; bus0.e_req_i = 1'b0; bus0.e_we_i = 1'b0; bus0.e_addr_i = '0;
    bus0.e_be_i = '0; bus0.e_wdata_i = '0;
    bus1.c_req_i = 1'b0; bus1.c_we_i = 1'b0; bus1.c_addr_i = '0; bus1.c_funct3_i = '0;
    bus1.c_wdata_i = '0; bus1.e_req_i = 1'b0; bus1.e_we_i = 1'b0; bus1.e_addr_i = '0;
    bus1.e_be_i = '0; bus1.e_wdata_i = '0;
    test_reset();
    test_subword();
    test_errors();
    test_contention();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
